console_writer: RTL and testbench

Parametrised text-console write engine, successor to the fixed 128×64 keyboard-to-framestore writer. It accepts ASCII characters over a valid/ready handshake and writes glyph codes into the character frame-store write port (port B of the framestore). It keeps a cursor and interprets CR, LF, BS, TAB and FF, and auto-wraps at a configurable line length. Instead of stopping when the screen is full, it scrolls circularly: it clears the recycled row and advances `top_row`, which the display side uses as its row offset.

---
 rtl/console_writer.sv | 159 +++++++++++++++
 tb/tb_console_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/console_writer.sv
// Text-console write engine: turns a character stream into glyph writes on the
// framestore write port, with cursor control, auto-wrap and circular scrolling.
module console_writer #(
    parameter int         COL_W    = 7,
    parameter int         ROW_W    = 6,
    parameter int         LINE_LEN = 80,
    parameter logic [7:0] FILL     = 8'h20
) (
    input  logic                   clk_p,
    input  logic                   rst,
    input  logic                   ch_valid,
    input  logic [7:0]             ch_data,
    output logic                   ch_ready,
    output logic [COL_W+ROW_W-1:0] mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_we,
    output logic [COL_W-1:0]       cursor_col,
    output logic [ROW_W-1:0]       cursor_row,
    output logic [ROW_W-1:0]       top_row,
    output logic                   busy
);
    localparam int              AW       = COL_W + ROW_W;
    localparam logic [AW:0]     ALL_END  = (AW+1)'(1) << AW;
    localparam logic [AW:0]     LINE_END = (AW+1)'(1) << COL_W;
    localparam logic [COL_W:0]  LEN      = (COL_W+1)'(LINE_LEN);
    localparam logic [7:0]      FILL7    = {1'b0, FILL[6:0]};

    typedef enum logic [1:0] {CLEAR_ALL, IDLE, STEP, CLEAR_LINE} state_t;

    state_t           state, state_nx;
    logic [AW:0]      cnt, cnt_nx;
    logic [6:0]       chr, chr_nx;
    logic [COL_W-1:0] col_nx;
    logic [ROW_W-1:0] row_nx, top_nx, row_inc;
    logic [AW-1:0]    addr_nx;
    logic [7:0]       wdata_nx;
    logic             we_nx, nl;
    logic [COL_W:0]   col_inc, col_tab;
    logic             unused;

    assign unused   = ch_data[7];
    assign ch_ready = (state == IDLE);
    assign busy     = ~ch_ready;
    assign row_inc  = cursor_row + 1'b1;
    assign col_inc  = {1'b0, cursor_col} + (COL_W+1)'(1);
    assign col_tab  = ({1'b0, cursor_col} | (COL_W+1)'(7)) + (COL_W+1)'(1);

    function automatic logic printable(input logic [6:0] c);
        return (c >= 7'h20) && (c != 7'h7f);
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        chr_nx   = chr;
        col_nx   = cursor_col;
        row_nx   = cursor_row;
        top_nx   = top_row;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        we_nx    = 1'b0;
        nl       = 1'b0;
        case (state)
            CLEAR_ALL, CLEAR_LINE: begin
                if (cnt == ((state == CLEAR_ALL) ? ALL_END : LINE_END)) begin
                    state_nx = IDLE;
                end else begin
                    we_nx    = 1'b1;
                    wdata_nx = FILL7;
                    addr_nx  = (state == CLEAR_ALL) ? cnt[AW-1:0]
                                                    : {cursor_row, cnt[COL_W-1:0]};
                    cnt_nx   = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (ch_valid) begin
                    // The write is registered at acceptance so it lands in the STEP cycle.
                    chr_nx   = ch_data[6:0];
                    state_nx = STEP;
                    if (printable(ch_data[6:0])) begin
                        we_nx    = 1'b1;
                        addr_nx  = {cursor_row, cursor_col};
                        wdata_nx = {1'b0, ch_data[6:0]};
                    end else if (ch_data[6:0] == 7'h08 && cursor_col != '0) begin
                        we_nx    = 1'b1;
                        addr_nx  = {cursor_row, cursor_col - 1'b1};
                        wdata_nx = FILL7;
                    end
                end
            end
            STEP: begin
                state_nx = IDLE;
                if (printable(chr)) begin
                    if (col_inc == LEN) nl = 1'b1;
                    else                col_nx = col_inc[COL_W-1:0];
                end else begin
                    case (chr)
                        7'h0a: nl = 1'b1;
                        7'h0d: col_nx = '0;
                        7'h08: if (cursor_col != '0) col_nx = cursor_col - 1'b1;
                        7'h09: begin
                            if (col_tab >= LEN) nl = 1'b1;
                            else                col_nx = col_tab[COL_W-1:0];
                        end
                        7'h0c: begin
                            state_nx = CLEAR_ALL;
                            col_nx   = '0;
                            row_nx   = '0;
                            top_nx   = '0;
                            we_nx    = 1'b1;
                            addr_nx  = '0;
                            wdata_nx = FILL7;
                            cnt_nx   = (AW+1)'(1);
                        end
                        default: ;
                    endcase
                end
                if (nl) begin
                    col_nx = '0;
                    row_nx = row_inc;
                    // Screen full: recycle the new row and scroll the display window.
                    if (row_inc == top_row) begin
                        top_nx   = top_row + 1'b1;
                        state_nx = CLEAR_LINE;
                        we_nx    = 1'b1;
                        addr_nx  = {row_inc, {COL_W{1'b0}}};
                        wdata_nx = FILL7;
                        cnt_nx   = (AW+1)'(1);
                    end
                end
            end
            default: state_nx = CLEAR_ALL;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            state      <= CLEAR_ALL;
            cnt        <= '0;
            chr        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= FILL7;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            chr        <= chr_nx;
            cursor_col <= col_nx;
            cursor_row <= row_nx;
            top_row    <= top_nx;
            mem_we     <= we_nx;
            mem_addr   <= addr_nx;
            mem_wdata  <= wdata_nx;
        end
    end
endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a behavioural cursor model queues the
// expected framestore writes, a negedge monitor pops and compares them.
module tb_console_writer;
    localparam int LIM = 20000;

    logic        clk_p = 1'b0, rst = 1'b1, ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_ready, mem_we, busy;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row, top_row;

    console_writer dut (
        .clk_p(clk_p), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ready(ch_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .top_row(top_row), .busy(busy)
    );

    always #5 clk_p = ~clk_p;

    int          n_chk = 0, n_fail = 0;
    logic [20:0] exp_q[$];
    int          m_col = 0, m_row = 0, m_top = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_p) begin
        if (mem_we === 1'b1) begin
            chk("wr_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("wr", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    task automatic push_row(input int r);
        for (int i = 0; i < 128; i++) exp_q.push_back({13'(r*128 + i), 8'h20});
    endtask

    task automatic push_all();
        for (int i = 0; i < 8192; i++) exp_q.push_back({13'(i), 8'h20});
    endtask

    task automatic m_newline();
        m_col = 0;
        m_row = (m_row + 1) % 64;
        if (m_row == m_top) begin
            m_top = (m_top + 1) % 64;
            push_row(m_row);
        end
    endtask

    task automatic model(input logic [7:0] d);
        int c;
        c = int'(d) & 127;
        if (c >= 32 && c != 127) begin
            exp_q.push_back({13'(m_row*128 + m_col), 8'(c)});
            m_col++;
            if (m_col == 80) m_newline();
        end else if (c == 10) m_newline();
        else if (c == 13) m_col = 0;
        else if (c == 8) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back({13'(m_row*128 + m_col), 8'h20});
            end
        end else if (c == 9) begin
            m_col = (m_col | 7) + 1;
            if (m_col >= 80) m_newline();
        end else if (c == 12) begin
            m_col = 0; m_row = 0; m_top = 0;
            push_all();
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!ch_ready && n < LIM) begin @(negedge clk_p); n++; end
        if (n >= LIM) chk("send_timeout", 32'(ch_ready), 1);
        ch_valid = 1'b1;
        ch_data  = d;
        model(d);
        @(posedge clk_p); #1;
        ch_valid = 1'b0;
        ch_data  = 8'($urandom);
    endtask

    // Counts busy cycles observed on negedges until ch_ready is seen.
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk_p);
        while (!ch_ready && n < LIM) begin n++; @(negedge clk_p); end
        chk("rdy", 32'(ch_ready), 1);
        chk("busy_inv", 32'(busy), 32'(!ch_ready));
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(cursor_col), 32'(m_col));
        chk({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        chk({tag, "_top"}, 32'(top_row), 32'(m_top));
        chk({tag, "_q"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk_p);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 32'h20);
        chk("rst_ready", 32'(ch_ready), 0);
        chk("rst_busy", 32'(busy), 1);
        push_all();
        rst = 1'b0;
        fork
            wait_ready(n);
            begin
                ch_valid = 1'b1;
                repeat (50) begin ch_data = 8'($urandom); @(negedge clk_p); end
                ch_valid = 1'b0;
            end
        join
        chk("clr_all_cycles", n, 8192);
        chk_cursor("after_rst");

        for (int i = 0; i < 80; i++) send("A");
        wait_ready(n);
        chk("step_busy", n, 1);
        chk("wrap_row", 32'(cursor_row), 1);
        chk("wrap_col", 32'(cursor_col), 0);
        send("B");
        wait_ready(n);
        chk_cursor("wrap_b");

        send(8'h0d); send("H"); send("i"); send(8'h0d); send("J");
        wait_ready(n);
        chk("hi_col", 32'(cursor_col), 1);
        chk_cursor("hi");

        send(8'h0d); send(8'h08);
        wait_ready(n);
        chk("bs0_col", 32'(cursor_col), 0);
        send("1"); send("2"); send("3"); send("4"); send("5"); send(8'h08);
        wait_ready(n);
        chk("bs5_col", 32'(cursor_col), 4);
        chk_cursor("bs5");
        send(8'h0d); send("1"); send("2"); send("3"); send(8'h09);
        wait_ready(n);
        chk("tab3_col", 32'(cursor_col), 8);
        for (int i = 0; i < 67; i++) send("x");
        send(8'h89);
        wait_ready(n);
        chk("tab75_col", 32'(cursor_col), 0);
        chk_cursor("tab75");

        while (m_row != 63) send(8'h0a);
        wait_ready(n);
        chk_cursor("row63");
        send(8'h0a);
        wait_ready(n);
        chk("scroll1_busy", n, 129);
        chk("scroll1_top", 32'(top_row), 1);
        chk_cursor("scroll1");
        send(8'h0a);
        wait_ready(n);
        chk("scroll2_top", 32'(top_row), 2);
        chk_cursor("scroll2");

        while (m_row != 63) send(8'h0a);
        send(8'h7f); send(8'h01);
        wait_ready(n);
        chk_cursor("full63");
        send(8'h0a);
        n = 0;
        while (!(mem_we === 1'b1 && mem_addr == 13'h0040) && n < LIM) begin
            @(negedge clk_p); n++;
        end
        chk("hit_0040", 32'(mem_addr), 32'h0040);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk_p);
        chk("mid_rst_we", 32'(mem_we), 0);
        m_col = 0; m_row = 0; m_top = 0;
        push_all();
        rst = 1'b0;
        wait_ready(n);
        chk("mid_rst_cycles", n, 8192);
        chk_cursor("mid_rst");

        send(8'h0a); send(8'h0a);
        for (int i = 0; i < 20; i++) send(8'($urandom_range(32, 126)));
        wait_ready(n);
        chk_cursor("pre_ff");
        send(8'h0c);
        @(negedge clk_p); @(negedge clk_p);
        chk("ff_entry_col", 32'(cursor_col), 0);
        chk("ff_entry_row", 32'(cursor_row), 0);
        wait_ready(n);
        chk("ff_cycles", n, 8191);
        chk_cursor("ff");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
